regfile_multi_port: RTL and testbench
=====================================

# regfile_multi_port

Parametrised multi-read, dual-write register file for the datapath's operand store; generalises the dual-read RAM. It has N registered read ports and two independent write ports: the primary ALU result port and a secondary port, such as the multiply high-part, with a programmable address. It adds asynchronous clear, defined out-of-range behaviour, deterministic write-collision resolution with a sticky flag, and optional read-during-write forwarding. It sits between instruction decode (read addresses) and the execute/writeback stage (write ports).

## Interface
- DATA_WIDTH, 16, bits per entry
- ADDR_WIDTH, 8, address bits on every port
- MEM_SIZE, 8, highest valid index; entries 0..MEM_SIZE (MEM_SIZE+1 entries, MEM_SIZE < 2^ADDR_WIDTH)
- NUM_READ, 2, number of read ports (1..8)

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- iWriteEnable0  in  1  primary write strobe
- iWriteAddress0  in  ADDR_WIDTH  primary write index
- iDataIn0  in  DATA_WIDTH  primary write data
- iWriteEnable1  in  1  secondary write strobe (e.g. multiply high part)
- iWriteAddress1  in  ADDR_WIDTH  secondary write index
- iDataIn1  in  DATA_WIDTH  secondary write data
- iReadAddress  in  NUM_READ*ADDR_WIDTH  flattened; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  out  NUM_READ*DATA_WIDTH  flattened; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- oCollision  out  1  sticky; set when both write ports hit the same valid address in one cycle
- iClearCollision  in  1  synchronous clear of oCollision

## Operation
- Reset asserted: all entries, all oDataOut lanes and oCollision go to 0 immediately, with no clock needed. The block holds this state while Reset is high.
- Write: on a rising edge, each enabled port with address ≤ MEM_SIZE updates its entry.
- Out-of-range write address: the write is silently dropped; no other entry changes.
- Both ports enabled, same valid address: port 1 (secondary) wins and port 0 data is discarded; oCollision is set at the same edge.
- Both ports enabled, different addresses: both writes commit.
- Read: every edge, lane k registers Ram[address k]. Reads are unconditional, with no enable.
- Out-of-range read address: lane k registers 0.
- Several lanes reading the same address is legal; all return the same value.
- oCollision update: iClearCollision with no new collision clears it; clear and a new collision in the same cycle leaves it set (set wins).

## Timing
- Read latency: 1 cycle. The address is sampled at edge N and the data is valid after edge N.
- Write latency: 1 cycle. Data written at edge N is readable by an address presented at edge N+1 (visible on oDataOut after edge N+1).
- Read-during-write, same address, same edge: the result depends on the forwarding macro (see Configuration).
- Reset deasserting mid-operation: the first edge after deassertion performs normal writes and reads. There is no extra warm-up cycle.
- Reset asserting between edges: any pending write is lost and the entries read 0.

## Configuration
- RF_BYPASS_EN defined:
  - A read lane whose address matches an enabled, valid write address in the same cycle registers the incoming write data instead of the stored value.
  - When both write ports match, port 1 data is forwarded, consistent with collision priority.
  - Effective read-after-write distance is 0 cycles.
- RF_BYPASS_EN undefined:
  - The same-cycle read returns the old stored value (read-before-write).
  - The new value appears on the next read.
  - Forwarding muxes are not synthesised.

## Test plan
- Reset mid-run: write 0xBEEF to entry 3, assert Reset between edges -> oDataOut and oCollision are 0 immediately; after release, reading 3 returns 0x0000.
- Basic write/read with NUM_READ=2: write 0x1234 to 2 and 0xABCD to 5; next cycle read ports 0/1 = 2/5 -> lanes show 0x1234/0xABCD one cycle after the addresses are applied.
- Collision: port 0 writes 0x1111 and port 1 writes 0x2222, both to entry 4 -> entry 4 = 0x2222, oCollision = 1 and stays 1; pulse iClearCollision -> 0.
- Out-of-range with MEM_SIZE=8: write 0x5555 to address 9, then read 9 and all of 0..8 -> address 9 reads 0x0000 and every other entry is unchanged.
- Read-during-write: entry 6 holds 0x0001; write 0x00FF to 6 while reading 6 at the same edge -> lane shows 0x00FF with RF_BYPASS_EN, 0x0001 without; the next read shows 0x00FF in both builds.
- Dual write, distinct addresses, all lanes same address: write 0xAAAA to 1 and 0xBBBB to 7; next cycle all lanes read 7 -> every lane shows 0xBBBB, entry 1 = 0xAAAA, oCollision stays 0.

Source files
------------

// File: rtl/regfile_multi_port.sv
// regfile_multi_port: N registered read lanes, two write ports, sticky collision flag.
// Define RF_BYPASS_EN to forward same-edge write data onto matching read lanes.
module regfile_multi_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8,
  parameter int NUM_READ   = 2
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           iWriteEnable0,
  input  logic [ADDR_WIDTH-1:0]          iWriteAddress0,
  input  logic [DATA_WIDTH-1:0]          iDataIn0,
  input  logic                           iWriteEnable1,
  input  logic [ADDR_WIDTH-1:0]          iWriteAddress1,
  input  logic [DATA_WIDTH-1:0]          iDataIn1,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
  output logic                           oCollision,
  input  logic                           iClearCollision
);

  localparam int IDX_W =
    (MEM_SIZE > 0) ? $clog2(MEM_SIZE + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR =
    ADDR_WIDTH'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] ram [0:MEM_SIZE];

  logic we0_ok;
  logic we1_ok;
  logic collide;

  // Qualify each write port: enabled and in range.
  always_comb begin
    we0_ok  = iWriteEnable0 && (iWriteAddress0 <= MAX_ADDR);
    we1_ok  = iWriteEnable1 && (iWriteAddress1 <= MAX_ADDR);
    collide = we0_ok && we1_ok &&
              (iWriteAddress0 == iWriteAddress1);
  end

  // Storage update; port 1 overrides port 0 on a shared entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i <= MEM_SIZE; i++)
        ram[i] <= '0;
    end else begin
      for (int i = 0; i <= MEM_SIZE; i++) begin
        if (we1_ok && iWriteAddress1 == ADDR_WIDTH'(i))
          ram[i] <= iDataIn1;
        else if (we0_ok && iWriteAddress0 == ADDR_WIDTH'(i))
          ram[i] <= iDataIn0;
      end
    end
  end

  // Sticky collision flag; a new collision beats a clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      oCollision <= 1'b0;
    else if (collide)
      oCollision <= 1'b1;
    else if (iClearCollision)
      oCollision <= 1'b0;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_lane
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0] rd_q;

    assign raddr = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Select stored (or forwarded) data; out of range reads 0.
    always_comb begin
      rd_next = '0;
      if (raddr <= MAX_ADDR)
        rd_next = ram[raddr[IDX_W-1:0]];
`ifdef RF_BYPASS_EN
      if (we0_ok && raddr == iWriteAddress0)
        rd_next = iDataIn0;
      if (we1_ok && raddr == iWriteAddress1)
        rd_next = iDataIn1;
`endif
    end

    // Register the lane output every edge.
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
        rd_q <= '0;
      else
        rd_q <= rd_next;
    end

    assign oDataOut[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_multi_port.sv
// tb_regfile_multi_port: directed vectors for regfile_multi_port.
// Expected values are hand-derived; RF_BYPASS_EN selects the same-edge result.
module tb_regfile_multi_port;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        we0 = 1'b0;
  logic [7:0]  wa0 = '0;
  logic [15:0] wd0 = '0;
  logic        we1 = 1'b0;
  logic [7:0]  wa1 = '0;
  logic [15:0] wd1 = '0;
  logic [15:0] raddr;
  logic [31:0] dout;
  logic        coll;
  logic        clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model [0:8];

  regfile_multi_port #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .MEM_SIZE(8),
    .NUM_READ(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iWriteEnable0(we0),
    .iWriteAddress0(wa0),
    .iDataIn0(wd0),
    .iWriteEnable1(we1),
    .iWriteAddress1(wa1),
    .iDataIn1(wd1),
    .iReadAddress(raddr),
    .oDataOut(dout),
    .oCollision(coll),
    .iClearCollision(clr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input logic e0, input logic [7:0] a0,
                    input logic [15:0] d0, input logic e1,
                    input logic [7:0] a1, input logic [15:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
  endtask

  initial begin
    raddr = '0;
    for (int i = 0; i <= 8; i++) model[i] = '0;

    // reset at start
    #1 Reset = 1'b1;
    #1;
    check("rst_lanes", dout, 32'h0);
    check("rst_coll", coll, 1'b0);
    tick();
    tick();
    Reset = 1'b0;

    // basic dual write, then read 2/5
    wr(1, 8'd2, 16'h1234, 1, 8'd5, 16'hABCD);
    tick();
    model[2] = 16'h1234; model[5] = 16'hABCD;
    wr(0, 0, 0, 0, 0, 0);
    rd(8'd2, 8'd5);
    tick();
    check("basic_l0", dout[15:0], 16'h1234);
    check("basic_l1", dout[31:16], 16'hABCD);
    check("basic_coll", coll, 1'b0);

    // collision on entry 4
    wr(1, 8'd4, 16'h1111, 1, 8'd4, 16'h2222);
    tick();
    model[4] = 16'h2222;
    check("coll_set", coll, 1'b1);
    wr(0, 0, 0, 0, 0, 0);
    rd(8'd4, 8'd4);
    tick();
    check("coll_data", dout[15:0], 16'h2222);
    check("coll_sticky", coll, 1'b1);
    clr = 1'b1;
    tick();
    check("coll_clr", coll, 1'b0);
    // clear and new collision together: set wins
    wr(1, 8'd4, 16'h2222, 1, 8'd4, 16'h2222);
    tick();
    check("coll_setwins", coll, 1'b1);
    wr(0, 0, 0, 0, 0, 0);
    tick();
    check("coll_clr2", coll, 1'b0);
    clr = 1'b0;

    // out-of-range writes, including a same-address pair
    wr(1, 8'd9, 16'h5555, 0, 0, 0);
    tick();
    wr(1, 8'd9, 16'h6666, 1, 8'd9, 16'h7777);
    tick();
    check("oor_nocoll", coll, 1'b0);
    wr(0, 0, 0, 0, 0, 0);
    for (int e = 0; e <= 8; e++) begin
      rd(8'd9, 8'(e));
      tick();
      check($sformatf("oor_rd9_%0d", e), dout[15:0], 16'h0);
      check($sformatf("oor_ent%0d", e), dout[31:16], model[e]);
    end
    rd(8'hFF, 8'd0);
    tick();
    check("oor_rdFF", dout[15:0], 16'h0);

    // read during write on entry 6
    wr(1, 8'd6, 16'h0001, 0, 0, 0);
    tick();
    wr(1, 8'd6, 16'h00FF, 0, 0, 0);
    rd(8'd6, 8'd6);
    tick();
`ifdef RF_BYPASS_EN
    check("rdw_same", dout[15:0], 16'h00FF);
`else
    check("rdw_same", dout[15:0], 16'h0001);
`endif
    wr(0, 0, 0, 0, 0, 0);
    tick();
    check("rdw_next", dout[31:16], 16'h00FF);

    // port 1 forwarded when both ports hit the read address
    wr(1, 8'd6, 16'h0A0A, 1, 8'd6, 16'h0B0B);
    tick();
`ifdef RF_BYPASS_EN
    check("rdw_both", dout[15:0], 16'h0B0B);
`else
    check("rdw_both", dout[15:0], 16'h00FF);
`endif
    wr(0, 0, 0, 0, 0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("rdw_both_nx", dout[15:0], 16'h0B0B);

    // dual write, distinct addresses, all lanes read 7
    wr(1, 8'd1, 16'hAAAA, 1, 8'd7, 16'hBBBB);
    tick();
    wr(0, 0, 0, 0, 0, 0);
    rd(8'd7, 8'd7);
    tick();
    check("dual_l0", dout[15:0], 16'hBBBB);
    check("dual_l1", dout[31:16], 16'hBBBB);
    rd(8'd1, 8'd1);
    tick();
    check("dual_e1", dout[15:0], 16'hAAAA);
    check("dual_coll", coll, 1'b0);

    // reset mid-run
    wr(1, 8'd3, 16'h1111, 1, 8'd3, 16'hBEEF);
    tick();
    wr(0, 0, 0, 0, 0, 0);
    rd(8'd3, 8'd3);
    tick();
    check("mid_pre", dout[15:0], 16'hBEEF);
    check("mid_pre_coll", coll, 1'b1);
    wr(1, 8'd2, 16'h4444, 0, 0, 0);
    #2 Reset = 1'b1;
    #1;
    check("mid_lanes", dout, 32'h0);
    check("mid_coll", coll, 1'b0);
    tick();
    check("mid_hold", dout, 32'h0);
    Reset = 1'b0;
    wr(1, 8'd0, 16'h7777, 0, 0, 0);
    rd(8'd3, 8'd2);
    tick();
    check("mid_rd3", dout[15:0], 16'h0);
    check("mid_rd2", dout[31:16], 16'h0);
    wr(0, 0, 0, 0, 0, 0);
    rd(8'd0, 8'd0);
    tick();
    check("mid_first", dout[15:0], 16'h7777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
